temporal_select_mux: RTL and testbench

- Multi-channel binary-to-temporal select mux for the race-logic / TNN datapath.
- A free-running gamma-cycle counter timestamps the first arrival of each temporal select line within a gamma cycle.
- Binary-coded spike times whose value matches the captured time (EQ mode) or precedes it (LE mode) are forwarded as registered binary outputs and as PULSE_WIDTH-cycle temporal spikes.
- All state clears at every gamma-cycle boundary.

---
 rtl/tnn_temporal_pkg.sv | 18 +
 rtl/gamma_capture_chan.sv | 91 +++++++++
 rtl/temporal_select_mux.sv | 85 ++++++++
 tb/tb_temporal_select_mux.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_temporal_pkg.sv
// rtl/tnn_temporal_pkg.sv - shared types and spike-code helpers for the temporal select mux
package tnn_temporal_pkg;

    typedef enum logic {
        MODE_EQ = 1'b0,
        MODE_LE = 1'b1
    } mode_e;

    // The NULL (infinite) spike time is encoded as the gamma-cycle length itself.
    function automatic int unsigned null_code(input int unsigned g);
        return g;
    endfunction

    function automatic logic is_null(input int unsigned code, input int unsigned g);
        return code >= g;
    endfunction

endpackage

// File: rtl/gamma_capture_chan.sv
// rtl/gamma_capture_chan.sv - one temporal select channel: capture, late drop, match and spike
module gamma_capture_chan
    import tnn_temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_MEMBERS       = 4,
    parameter int CNT_WIDTH         = 4,
    parameter int INPUT_WIDTH       = 5
) (
    input  logic                                   grst,
    input  logic                                   aclk,
    input  logic [CNT_WIDTH-1:0]                   i_cnt,
    input  logic                                   i_last,
    input  mode_e                                  i_mode,
    input  logic                                   i_sel,
    input  logic [NUM_MEMBERS-1:0][INPUT_WIDTH-1:0] i_in,
    output logic                                   o_cap_valid,
    output logic [CNT_WIDTH-1:0]                   o_cap_time,
    output logic                                   o_late_drop,
    output logic [NUM_MEMBERS-1:0][INPUT_WIDTH-1:0] o_out,
    output logic [NUM_MEMBERS-1:0]                 o_spike
);

    localparam logic [INPUT_WIDTH-1:0] NULL_CODE = INPUT_WIDTH'(null_code(GAMMA_CYCLE_WIDTH));
    localparam int PCW = $clog2(PULSE_WIDTH + 1);

    logic                                   r_valid;
    logic [CNT_WIDTH-1:0]                   r_time;
    logic                                   r_late;
    logic [NUM_MEMBERS-1:0][INPUT_WIDTH-1:0] r_out;
    logic [NUM_MEMBERS-1:0]                 r_spike;
    logic [PCW-1:0]                         r_pcnt;

    logic                                   w_cap;
    logic [INPUT_WIDTH-1:0]                 w_t_ext;
    logic [NUM_MEMBERS-1:0]                 w_match;

    // The last cycle of a gamma cycle never captures; it can only be reported as late.
    assign w_cap   = i_sel && !r_valid && !i_last;
    assign w_t_ext = INPUT_WIDTH'(i_cnt);

    always_comb begin
        w_match = '0;
        for (int k = 0; k < NUM_MEMBERS; k++) begin
            if (!is_null(32'(i_in[k]), GAMMA_CYCLE_WIDTH)) begin
                w_match[k] = (i_mode == MODE_LE) ? (i_in[k] <= w_t_ext) : (i_in[k] == w_t_ext);
            end
        end
    end

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            r_valid <= 1'b0;
            r_time  <= '0;
            r_late  <= 1'b0;
            r_out   <= {NUM_MEMBERS{NULL_CODE}};
            r_spike <= '0;
            r_pcnt  <= '0;
        end else if (i_last) begin
            r_valid <= 1'b0;
            r_time  <= '0;
            r_late  <= i_sel && !r_valid;
            r_out   <= {NUM_MEMBERS{NULL_CODE}};
            r_spike <= '0;
            r_pcnt  <= '0;
        end else begin
            r_late <= 1'b0;
            if (w_cap) begin
                r_valid <= 1'b1;
                r_time  <= i_cnt;
                r_pcnt  <= PCW'(PULSE_WIDTH - 1);
                r_spike <= w_match;
                for (int k = 0; k < NUM_MEMBERS; k++) begin
                    r_out[k] <= w_match[k] ? i_in[k] : NULL_CODE;
                end
            end else if (r_pcnt != '0) begin
                r_pcnt <= r_pcnt - PCW'(1);
            end else begin
                r_spike <= '0;
            end
        end
    end

    assign o_cap_valid = r_valid;
    assign o_cap_time  = r_time;
    assign o_late_drop = r_late;
    assign o_out       = r_out;
    assign o_spike     = r_spike;

endmodule

// File: rtl/temporal_select_mux.sv
// rtl/temporal_select_mux.sv - gamma counter, mode sampling and per-channel capture array
module temporal_select_mux
    import tnn_temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_INPUTS        = 16,
    parameter int NUM_SELECTS       = 4,
    parameter int CNT_WIDTH         = $clog2(GAMMA_CYCLE_WIDTH),
    parameter int INPUT_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH + 1)
) (
    input  logic                                   grst,
    input  logic                                   aclk,
    input  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] inputs,
    input  logic [NUM_SELECTS-1:0]                 select,
    input  logic                                   mode,
    output logic                                   gamma_start,
    output logic [NUM_SELECTS-1:0]                 cap_valid,
    output logic [NUM_SELECTS-1:0][CNT_WIDTH-1:0]  cap_time,
    output logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] out,
    output logic [NUM_INPUTS-1:0]                  out_spike,
    output logic [NUM_SELECTS-1:0]                 late_drop
);

    logic [CNT_WIDTH-1:0] r_cnt;
    mode_e                r_mode_q;
    logic                 w_zero;
    logic                 w_last;
    mode_e                w_mode_eff;

    assign w_zero = (r_cnt == '0);
    assign w_last = (r_cnt == CNT_WIDTH'(GAMMA_CYCLE_WIDTH - 1));

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            r_cnt    <= '0;
            r_mode_q <= MODE_EQ;
        end else begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_WIDTH'(1);
            if (w_zero) begin
                r_mode_q <= mode_e'(mode);
            end
        end
    end

    // A capture in the counter==0 cycle must see the live mode, not last cycle's sample.
    assign w_mode_eff  = w_zero ? mode_e'(mode) : r_mode_q;
    assign gamma_start = w_zero;

    for (genvar c = 0; c < NUM_SELECTS; c++) begin : g_chan
        localparam int NM = (NUM_INPUTS - c + NUM_SELECTS - 1) / NUM_SELECTS;

        logic [NM-1:0][INPUT_WIDTH-1:0] w_in;
        logic [NM-1:0][INPUT_WIDTH-1:0] w_out;
        logic [NM-1:0]                  w_spk;

        for (genvar k = 0; k < NM; k++) begin : g_member
            assign w_in[k]                     = inputs[c + k * NUM_SELECTS];
            assign out[c + k * NUM_SELECTS]       = w_out[k];
            assign out_spike[c + k * NUM_SELECTS] = w_spk[k];
        end

        gamma_capture_chan #(
            .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
            .PULSE_WIDTH       (PULSE_WIDTH),
            .NUM_MEMBERS       (NM),
            .CNT_WIDTH         (CNT_WIDTH),
            .INPUT_WIDTH       (INPUT_WIDTH)
        ) u_chan (
            .grst        (grst),
            .aclk        (aclk),
            .i_cnt       (r_cnt),
            .i_last      (w_last),
            .i_mode      (w_mode_eff),
            .i_sel       (select[c]),
            .i_in        (w_in),
            .o_cap_valid (cap_valid[c]),
            .o_cap_time  (cap_time[c]),
            .o_late_drop (late_drop[c]),
            .o_out       (w_out),
            .o_spike     (w_spk)
        );
    end

endmodule

// File: tb/tb_temporal_select_mux.sv
// tb/tb_temporal_select_mux.sv - scoreboard bench for temporal_select_mux
module tb_temporal_select_mux;

    localparam int G  = 16;
    localparam int PW = 8;
    localparam int NI = 16;
    localparam int NS = 4;
    localparam int CW = 4;
    localparam int IW = 5;

    typedef logic [NI-1:0][IW-1:0] vec_t;

    typedef struct {
        logic                   gs;
        logic [NS-1:0]          cv;
        logic [NS-1:0][CW-1:0]  ct;
        vec_t                   o;
        logic [NI-1:0]          sp;
        logic [NS-1:0]          ld;
    } exp_t;

    logic                  grst;
    logic                  aclk;
    vec_t                  inputs;
    logic [NS-1:0]         select;
    logic                  mode;
    logic                  gamma_start;
    logic [NS-1:0]         cap_valid;
    logic [NS-1:0][CW-1:0] cap_time;
    vec_t                  out;
    logic [NI-1:0]         out_spike;
    logic [NS-1:0]         late_drop;

    exp_t          sb[$];
    int            n_vec = 0;
    int            n_bad = 0;
    logic [NS-1:0] sched [G];
    bit            late_prev [NS];

    temporal_select_mux #(
        .GAMMA_CYCLE_WIDTH (G),
        .PULSE_WIDTH       (PW),
        .NUM_INPUTS        (NI),
        .NUM_SELECTS       (NS)
    ) dut (
        .grst        (grst),
        .aclk        (aclk),
        .inputs      (inputs),
        .select      (select),
        .mode        (mode),
        .gamma_start (gamma_start),
        .cap_valid   (cap_valid),
        .cap_time    (cap_time),
        .out         (out),
        .out_spike   (out_spike),
        .late_drop   (late_drop)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t null_vec();
        vec_t v;
        for (int i = 0; i < NI; i++) v[i] = IW'(G);
        return v;
    endfunction

    function automatic exp_t rst_exp();
        exp_t e;
        e.gs = 1'b1;
        e.cv = '0;
        e.ct = '0;
        e.o  = null_vec();
        e.sp = '0;
        e.ld = '0;
        return e;
    endfunction

    task automatic clear_sched();
        for (int k = 0; k < G; k++) sched[k] = '0;
    endtask

    // Reference model: derive each channel's first legal select time for the whole gamma
    // cycle, then what every output must show at each counter value.
    task automatic run_gamma(input vec_t in_v, input logic mode0, input int abort_at);
        int   cap_t [NS];
        bit   nl [NS];
        bit   m [NI];
        exp_t e;
        for (int c = 0; c < NS; c++) begin
            cap_t[c] = -1;
            for (int k = 0; k < G - 1; k++)
                if (sched[k][c] && cap_t[c] < 0) cap_t[c] = k;
            nl[c] = sched[G-1][c] && (cap_t[c] < 0);
        end
        for (int i = 0; i < NI; i++) begin
            int c    = i % NS;
            int code = int'(in_v[i]);
            m[i] = (cap_t[c] >= 0) && (code < G) &&
                   (mode0 ? (code <= cap_t[c]) : (code == cap_t[c]));
        end
        for (int k = 0; k < G; k++) begin
            if (k == abort_at) begin
                grst = 1'b1;
                for (int r = 0; r < 3; r++) begin
                    sb.push_back(rst_exp());
                    @(posedge aclk); #1;
                end
                grst = 1'b0;
                for (int c = 0; c < NS; c++) late_prev[c] = 1'b0;
                return;
            end
            inputs = in_v;
            select = sched[k];
            mode   = (k == 0) ? mode0 : 1'($urandom);
            e.gs = (k == 0);
            for (int c = 0; c < NS; c++) begin
                bit v = (cap_t[c] >= 0) && (cap_t[c] < k);
                e.cv[c] = v;
                e.ct[c] = v ? CW'(cap_t[c]) : '0;
                e.ld[c] = (k == 0) && late_prev[c];
            end
            for (int i = 0; i < NI; i++) begin
                int c = i % NS;
                bit v = (cap_t[c] >= 0) && (cap_t[c] < k) && m[i];
                e.o[i]  = v ? in_v[i] : IW'(G);
                e.sp[i] = v && (k - cap_t[c] <= PW);
            end
            sb.push_back(e);
            @(posedge aclk); #1;
        end
        for (int c = 0; c < NS; c++) late_prev[c] = nl[c];
    endtask

    always @(negedge aclk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("gamma_start", 64'(gamma_start), 64'(e.gs));
            for (int c = 0; c < NS; c++) begin
                check($sformatf("cap_valid[%0d]", c), 64'(cap_valid[c]), 64'(e.cv[c]));
                check($sformatf("cap_time[%0d]", c), 64'(cap_time[c]), 64'(e.ct[c]));
                check($sformatf("late_drop[%0d]", c), 64'(late_drop[c]), 64'(e.ld[c]));
            end
            for (int i = 0; i < NI; i++) begin
                check($sformatf("out[%0d]", i), 64'(out[i]), 64'(e.o[i]));
                check($sformatf("out_spike[%0d]", i), 64'(out_spike[i]), 64'(e.sp[i]));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached with %0d pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin : driver
        vec_t v;
        grst   = 1'b1;
        inputs = null_vec();
        select = '0;
        mode   = 1'b0;
        for (int c = 0; c < NS; c++) late_prev[c] = 1'b0;
        @(posedge aclk); #1;
        repeat (2) begin
            sb.push_back(rst_exp());
            @(posedge aclk); #1;
        end
        grst = 1'b0;

        v = null_vec(); v[0] = 5; v[4] = 5; v[8] = 3;
        clear_sched();
        for (int k = 5; k < 10; k++) sched[k][0] = 1'b1;
        run_gamma(v, 1'b0, -1);
        run_gamma(v, 1'b1, -1);

        v = null_vec(); v[1] = 0;
        clear_sched(); sched[0][1] = 1'b1;
        run_gamma(v, 1'b0, -1);

        v = null_vec(); v[2] = 0; v[6] = 7;
        clear_sched(); sched[G-1][2] = 1'b1;
        run_gamma(v, 1'b1, -1);
        clear_sched(); sched[0][2] = 1'b1; sched[1][2] = 1'b1; sched[2][2] = 1'b1;
        run_gamma(v, 1'b0, -1);

        v = null_vec(); v[0] = 12; v[4] = 3;
        clear_sched(); sched[12][0] = 1'b1;
        run_gamma(v, 1'b1, -1);

        repeat (40) begin
            for (int i = 0; i < NI; i++) v[i] = IW'($urandom_range(0, 20));
            for (int k = 0; k < G; k++)
                for (int c = 0; c < NS; c++) sched[k][c] = ($urandom_range(0, 5) == 0);
            run_gamma(v, 1'($urandom), -1);
        end

        v = null_vec(); v[0] = 3; v[1] = 0; v[3] = 16;
        clear_sched(); sched[3][0] = 1'b1; sched[0][1] = 1'b1; sched[2][3] = 1'b1;
        run_gamma(v, 1'b1, 9);

        v = null_vec(); v[3] = 16; v[7] = 2; v[11] = 20;
        clear_sched(); sched[4][3] = 1'b1;
        run_gamma(v, 1'b1, -1);
        run_gamma(v, 1'b0, -1);

        for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge aclk);
        if (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
